ldu_aq_gate: RTL and testbench
==============================

# ldu_aq_gate

Load-side acquire gate that consumes the acquire advertisement from the store-AMO-fence unit acquire queue. Loads from the load pipeline enter a small buffer. A load is released downstream only when no active, un-killed acquire older than it exists in program order: mem loads wait on mem acquires, io loads wait on mem or io acquires. The block sits between load address generation and the load data-cache request stage.

## Interface
Parameters:
- ENTRIES, 4, buffer slots (power of 2, ≥2)
- PAYLOAD_WIDTH, 32, opaque load payload carried through unchanged

Ports (LOG_ROB_ENTRIES from core_types_pkg):
- Clocking and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- ldu_in_valid  in  1  load offered
- ldu_in_io  in  1  load is io-region (else mem)
- ldu_in_ROB_index  in  LOG_ROB_ENTRIES  absolute ROB index
- ldu_in_payload  in  PAYLOAD_WIDTH  passthrough data
- ldu_in_ready  out  1  slot available
- ldu_out_valid  out  1  released load present
- ldu_out_ROB_index  out  LOG_ROB_ENTRIES  released load ROB index
- ldu_out_payload  out  PAYLOAD_WIDTH  released load payload
- ldu_out_ready  in  1  downstream accepts
- rob_abs_head_index  in  LOG_ROB_ENTRIES  ROB head
- rob_kill_valid  in  1  kill this cycle
- rob_kill_rel_kill_younger_index  in  LOG_ROB_ENTRIES  kill entries with rel age ≥ this
- stamofu_aq_mem_aq_active  in  1  mem acquire outstanding
- stamofu_aq_mem_aq_oldest_abs_ROB_index  in  LOG_ROB_ENTRIES  oldest mem acquire
- stamofu_aq_io_aq_active  in  1  io acquire outstanding
- stamofu_aq_io_aq_oldest_abs_ROB_index  in  LOG_ROB_ENTRIES  oldest io acquire
- ldu_aq_stall_active  out  1  registered: some buffered load blocked last cycle

## Operation
- rel(x) = (x − rob_abs_head_index) mod 2^LOG_ROB_ENTRIES. All age comparisons use rel values and are unsigned.
- mem_block(e) = mem_aq_active & rel(e.ROB) > rel(mem_oldest).
- io_block(e) = io_aq_active & rel(e.ROB) > rel(io_oldest).
- blocked(e) = mem_block(e) | (e.io & io_block(e)). Equal rel is not blocked.
- Per-entry state: valid, io, ROB_index, payload.
- Enqueue: ldu_in_valid & ldu_in_ready writes the lowest-index free slot at the clock edge.
  - If rob_kill_valid is high that cycle and rel(ldu_in_ROB_index) ≥ kill index, the load is accepted but not written.
- Kill: a valid entry with rob_kill_valid & rel(ROB) ≥ kill index is invalidated at the edge. It is never released.
- Release candidate: the lowest-index entry that is valid, not newly killed this cycle, and not blocked.
  - ldu_out_valid is high when a candidate exists. out_ROB_index and out_payload come from that candidate.
  - Handshake ldu_out_valid & ldu_out_ready frees the candidate slot at the edge.
- ldu_in_ready = any slot invalid in current state. A slot freed in the same cycle does not count.
- ldu_aq_stall_active is registered as OR over valid entries of blocked(e).
- No ordering guarantee is made among released loads.

## Timing
- Reset: all entries invalid, ldu_in_ready=1, ldu_out_valid=0, out_ROB_index=0, out_payload=0 (all-zero when no candidate), ldu_aq_stall_active=0.
- Minimum latency is 1 cycle: a load accepted at edge t can be presented during cycle t+1. There is no combinational in→out bypass.
- ldu_out_valid, ROB index and payload are combinational from registered state, the advertisement inputs and the rob kill/head inputs. They may drop without a handshake if an acquire becomes active or a kill occurs; downstream must not assume stability.
- Full: ldu_in_ready=0 the whole cycle, even if a release happens that cycle.
- Simultaneous enqueue and release into different slots: both occur.
- Simultaneous kill and release of the same entry: out_valid is suppressed and the entry is invalidated.
- Wrap-around: ROB indices wrap mod 2^LOG_ROB_ENTRIES and all comparisons are relative to head.
- RST asserted mid-operation clears all entries at the next edge, regardless of other inputs.

## Test plan
(LOG_ROB_ENTRIES=7, ENTRIES=4)
- No acquire active, head=0: enqueue mem load ROB 5 with ldu_out_ready=1 → out_valid=1 with ROB 5 the next cycle; the slot is free the cycle after.
- mem_aq active with oldest=10, head=0: load ROB 12 is held (stall_active=1). Load ROB 8 is released. Drop mem_aq_active → ROB 12 released the next cycle.
- io_aq active with oldest=3, head=0: io load ROB 6 is blocked and mem load ROB 6 is released.
- Wrap: head=120, mem_aq oldest=125, load ROB 2 (rel 10 > 5) → blocked; load ROB 122 → released.
- Fill 4 blocked loads → in_ready=0. Release one while offering a fifth → fifth not accepted that cycle and accepted the next.
- Head=0, kill rel index 7 with entries ROB 4 and 9 blocked: ROB 9 is invalidated and never output. A simultaneous incoming load ROB 8 is dropped. ROB 4 is released once unblocked.

Source files
------------

// File: rtl/ldu_aq_gate.sv
// Load-side acquire gate: buffers loads and releases each one only when no older
// active acquire (mem for all loads, io additionally for io loads) is outstanding.
module ldu_aq_gate #(
    parameter int ENTRIES         = 4,
    parameter int PAYLOAD_WIDTH   = 32,
    parameter int LOG_ROB_ENTRIES = 7
) (
    input  logic                       CLK,
    input  logic                       RST,

    input  logic                       ldu_in_valid,
    input  logic                       ldu_in_io,
    input  logic [LOG_ROB_ENTRIES-1:0] ldu_in_ROB_index,
    input  logic [PAYLOAD_WIDTH-1:0]   ldu_in_payload,
    output logic                       ldu_in_ready,

    output logic                       ldu_out_valid,
    output logic [LOG_ROB_ENTRIES-1:0] ldu_out_ROB_index,
    output logic [PAYLOAD_WIDTH-1:0]   ldu_out_payload,
    input  logic                       ldu_out_ready,

    input  logic [LOG_ROB_ENTRIES-1:0] rob_abs_head_index,
    input  logic                       rob_kill_valid,
    input  logic [LOG_ROB_ENTRIES-1:0] rob_kill_rel_kill_younger_index,

    input  logic                       stamofu_aq_mem_aq_active,
    input  logic [LOG_ROB_ENTRIES-1:0] stamofu_aq_mem_aq_oldest_abs_ROB_index,
    input  logic                       stamofu_aq_io_aq_active,
    input  logic [LOG_ROB_ENTRIES-1:0] stamofu_aq_io_aq_oldest_abs_ROB_index,

    output logic                       ldu_aq_stall_active
);
    localparam int IDX_W = $clog2(ENTRIES);
    typedef logic [LOG_ROB_ENTRIES-1:0] rob_t;

    logic [ENTRIES-1:0]                    valid_q, valid_d;
    logic [ENTRIES-1:0]                    io_q, io_d;
    rob_t [ENTRIES-1:0]                    rob_q, rob_d;
    logic [ENTRIES-1:0][PAYLOAD_WIDTH-1:0] pay_q, pay_d;
    logic                                  stall_q;

    // Modular subtraction gives the age relative to the ROB head.
    function automatic rob_t rel(input rob_t x, input rob_t head);
        return x - head;
    endfunction

    rob_t mem_old_rel, io_old_rel, in_rel;
    assign mem_old_rel = rel(stamofu_aq_mem_aq_oldest_abs_ROB_index, rob_abs_head_index);
    assign io_old_rel  = rel(stamofu_aq_io_aq_oldest_abs_ROB_index, rob_abs_head_index);
    assign in_rel      = rel(ldu_in_ROB_index, rob_abs_head_index);

    logic [ENTRIES-1:0] kill_hit, blocked;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ent
        rob_t e_rel;
        assign e_rel        = rel(rob_q[gi], rob_abs_head_index);
        assign kill_hit[gi] = rob_kill_valid & (e_rel >= rob_kill_rel_kill_younger_index);
        assign blocked[gi]  = (stamofu_aq_mem_aq_active & (e_rel > mem_old_rel))
                            | (io_q[gi] & stamofu_aq_io_aq_active & (e_rel > io_old_rel));
    end

    logic             cand_found, free_found;
    logic [IDX_W-1:0] cand_idx, free_idx;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] & ~kill_hit[i] & ~blocked[i]) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
            end
            if (~valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign ldu_in_ready        = free_found;
    assign ldu_out_valid       = cand_found;
    assign ldu_out_ROB_index   = cand_found ? rob_q[cand_idx] : '0;
    assign ldu_out_payload     = cand_found ? pay_q[cand_idx] : '0;
    assign ldu_aq_stall_active = stall_q;

    logic enq_fire, deq_fire, in_killed;
    assign in_killed = rob_kill_valid & (in_rel >= rob_kill_rel_kill_younger_index);
    // A load killed on arrival is still handshaken, just never stored.
    assign enq_fire  = ldu_in_valid & ldu_in_ready & ~in_killed;
    assign deq_fire  = cand_found & ldu_out_ready;

    always_comb begin
        valid_d = valid_q & ~kill_hit;
        io_d    = io_q;
        rob_d   = rob_q;
        pay_d   = pay_q;
        if (deq_fire) begin
            valid_d[cand_idx] = 1'b0;
        end
        if (enq_fire) begin
            valid_d[free_idx] = 1'b1;
            io_d[free_idx]    = ldu_in_io;
            rob_d[free_idx]   = ldu_in_ROB_index;
            pay_d[free_idx]   = ldu_in_payload;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            stall_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            stall_q <= |(valid_q & blocked);
        end
        io_q  <= io_d;
        rob_q <= rob_d;
        pay_q <= pay_d;
    end
endmodule

// File: tb/tb_ldu_aq_gate.sv
// Directed bench for ldu_aq_gate: slot-level reference model checked every cycle,
// plus hand-computed expectations along each scenario.
module tb_ldu_aq_gate;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ldu_in_valid = 0, ldu_in_io = 0;
    logic [6:0]  ldu_in_ROB_index = 0;
    logic [31:0] ldu_in_payload = 0;
    logic        ldu_in_ready;
    logic        ldu_out_valid;
    logic [6:0]  ldu_out_ROB_index;
    logic [31:0] ldu_out_payload;
    logic        ldu_out_ready = 1;
    logic [6:0]  head = 0;
    logic        kill_v = 0;
    logic [6:0]  kidx = 0;
    logic        mem_act = 0, io_act = 0;
    logic [6:0]  mem_old = 0, io_old = 0;
    logic        ldu_aq_stall_active;

    int total = 0, passed = 0;
    bit go = 0;

    ldu_aq_gate #(.ENTRIES(4), .PAYLOAD_WIDTH(32), .LOG_ROB_ENTRIES(7)) dut (
        .CLK(CLK), .RST(RST),
        .ldu_in_valid(ldu_in_valid), .ldu_in_io(ldu_in_io),
        .ldu_in_ROB_index(ldu_in_ROB_index), .ldu_in_payload(ldu_in_payload),
        .ldu_in_ready(ldu_in_ready),
        .ldu_out_valid(ldu_out_valid), .ldu_out_ROB_index(ldu_out_ROB_index),
        .ldu_out_payload(ldu_out_payload), .ldu_out_ready(ldu_out_ready),
        .rob_abs_head_index(head), .rob_kill_valid(kill_v),
        .rob_kill_rel_kill_younger_index(kidx),
        .stamofu_aq_mem_aq_active(mem_act),
        .stamofu_aq_mem_aq_oldest_abs_ROB_index(mem_old),
        .stamofu_aq_io_aq_active(io_act),
        .stamofu_aq_io_aq_oldest_abs_ROB_index(io_old),
        .ldu_aq_stall_active(ldu_aq_stall_active)
    );

    always #5 CLK = ~CLK;

    // Reference model: four slots holding what the spec says each slot holds.
    bit        mv [4];
    bit        mio[4];
    bit [6:0]  mrob[4];
    bit [31:0] mpay[4];
    bit        mstall;

    function automatic bit [6:0] mrel(input bit [6:0] x);
        return 7'((int'(x) - int'(head) + 128) % 128);
    endfunction

    function automatic bit mkilled(input bit [6:0] r);
        return kill_v && (mrel(r) >= kidx);
    endfunction

    function automatic bit mblocked(int i);
        bit mb, ib;
        mb = mem_act && (mrel(mrob[i]) > mrel(mem_old));
        ib = io_act && (mrel(mrob[i]) > mrel(io_old));
        return mb || (mio[i] && ib);
    endfunction

    function automatic int mcand();
        for (int i = 0; i < 4; i++)
            if (mv[i] && !mkilled(mrob[i]) && !mblocked(i)) return i;
        return -1;
    endfunction

    function automatic int mfree();
        for (int i = 0; i < 4; i++)
            if (!mv[i]) return i;
        return -1;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) mv[i] = 0;
            mstall = 0;
        end else begin
            int c, f;
            bit st;
            c = mcand();
            f = mfree();
            st = 0;
            for (int i = 0; i < 4; i++) if (mv[i] && mblocked(i)) st = 1;
            for (int i = 0; i < 4; i++) if (mv[i] && mkilled(mrob[i])) mv[i] = 0;
            if (c >= 0 && ldu_out_ready) mv[c] = 0;
            if (ldu_in_valid && f >= 0 && !mkilled(ldu_in_ROB_index)) begin
                mv[f] = 1; mio[f] = ldu_in_io; mrob[f] = ldu_in_ROB_index; mpay[f] = ldu_in_payload;
            end
            mstall = st;
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    endtask

    always @(negedge CLK) begin
        if (go) begin
            int c;
            c = mcand();
            chk("m_out_valid", 32'(ldu_out_valid), 32'(c >= 0));
            chk("m_out_rob", 32'(ldu_out_ROB_index), (c >= 0) ? 32'(mrob[c]) : 32'd0);
            chk("m_out_pay", ldu_out_payload, (c >= 0) ? mpay[c] : 32'd0);
            chk("m_in_ready", 32'(ldu_in_ready), 32'(mfree() >= 0));
            chk("m_stall", 32'(ldu_aq_stall_active), 32'(mstall));
        end
    end

    task automatic tick(); @(posedge CLK); #1; endtask
    task automatic nw(); @(negedge CLK); endtask
    task automatic offer(input bit io, input bit [6:0] r, input bit [31:0] p);
        ldu_in_valid = 1; ldu_in_io = io; ldu_in_ROB_index = r; ldu_in_payload = p;
    endtask

    initial begin
        tick(); go = 1; tick(); RST = 0;
        nw();
        chk("rst_in_ready", 32'(ldu_in_ready), 1);
        chk("rst_out_valid", 32'(ldu_out_valid), 0);
        chk("rst_out_rob", 32'(ldu_out_ROB_index), 0);
        chk("rst_stall", 32'(ldu_aq_stall_active), 0);
        tick();

        // Basic pass-through, 1-cycle latency
        offer(0, 5, 32'hA5);
        nw(); chk("s1_no_bypass", 32'(ldu_out_valid), 0);
        tick(); ldu_in_valid = 0;
        nw(); chk("s1_valid", 32'(ldu_out_valid), 1);
        chk("s1_rob", 32'(ldu_out_ROB_index), 5);
        chk("s1_pay", ldu_out_payload, 32'hA5);
        tick();
        nw(); chk("s1_freed", 32'(ldu_out_valid), 0);
        tick();

        // mem acquire blocks younger mem load
        mem_act = 1; mem_old = 10;
        offer(0, 12, 12); tick();
        offer(0, 8, 8);
        nw(); chk("s2_held", 32'(ldu_out_valid), 0);
        tick(); ldu_in_valid = 0;
        nw(); chk("s2_rob8", 32'(ldu_out_ROB_index), 8);
        chk("s2_stall", 32'(ldu_aq_stall_active), 1);
        tick();
        nw(); chk("s2_idle", 32'(ldu_out_valid), 0);
        tick(); mem_act = 0;
        nw(); chk("s2_rob12", 32'(ldu_out_ROB_index), 12);
        tick();
        nw(); chk("s2_empty", 32'(ldu_out_valid), 0);
        chk("s2_stall0", 32'(ldu_aq_stall_active), 0);
        tick();

        // io acquire blocks only the io load
        io_act = 1; io_old = 3;
        offer(1, 6, 32'h106); tick();
        offer(0, 6, 32'h6);
        nw(); chk("s3_io_held", 32'(ldu_out_valid), 0);
        tick(); ldu_in_valid = 0;
        nw(); chk("s3_mem_pay", ldu_out_payload, 32'h6);
        tick(); io_act = 0;
        nw(); chk("s3_io_pay", ldu_out_payload, 32'h106);
        tick();

        // Wrap-around relative to head
        head = 120; mem_act = 1; mem_old = 125;
        offer(0, 2, 2); tick();
        offer(0, 122, 122); tick(); ldu_in_valid = 0;
        nw(); chk("s4_rob122", 32'(ldu_out_ROB_index), 122);
        tick();
        nw(); chk("s4_held", 32'(ldu_out_valid), 0);
        chk("s4_stall", 32'(ldu_aq_stall_active), 1);
        tick(); mem_act = 0;
        nw(); chk("s4_rob2", 32'(ldu_out_ROB_index), 2);
        tick(); head = 0;

        // Full buffer: release does not open a slot the same cycle
        mem_act = 1; mem_old = 0;
        for (int k = 0; k < 4; k++) begin
            offer(0, 7'(20 + k), 32'(20 + k)); tick();
        end
        offer(0, 24, 24); mem_old = 20;
        nw(); chk("s5_full", 32'(ldu_in_ready), 0);
        chk("s5_rob20", 32'(ldu_out_ROB_index), 20);
        tick();
        nw(); chk("s5_ready", 32'(ldu_in_ready), 1);
        chk("s5_none", 32'(ldu_out_valid), 0);
        tick(); ldu_in_valid = 0;
        nw(); chk("s5_full2", 32'(ldu_in_ready), 0);
        tick(); mem_act = 0;
        nw(); chk("s5_rob24", 32'(ldu_out_ROB_index), 24);
        repeat (4) tick();
        nw(); chk("s5_drained", 32'(ldu_out_valid), 0);
        tick();

        // Kill of blocked entries and of an incoming load
        mem_act = 1; mem_old = 2;
        offer(0, 4, 4); tick();
        offer(0, 9, 9); tick();
        offer(0, 8, 8); kill_v = 1; kidx = 7;
        nw(); chk("s6_ready", 32'(ldu_in_ready), 1);
        chk("s6_held", 32'(ldu_out_valid), 0);
        tick(); ldu_in_valid = 0; kill_v = 0; mem_act = 0;
        nw(); chk("s6_rob4", 32'(ldu_out_ROB_index), 4);
        tick();
        nw(); chk("s6_gone", 32'(ldu_out_valid), 0);
        tick();
        offer(0, 30, 30); tick(); ldu_in_valid = 0;
        kill_v = 1; kidx = 5;
        nw(); chk("s6_kill_rel", 32'(ldu_out_valid), 0);
        tick(); kill_v = 0;
        nw(); chk("s6_kill_gone", 32'(ldu_out_valid), 0);
        tick();

        // Reset mid-operation
        mem_act = 1; mem_old = 0;
        offer(0, 40, 40); tick();
        offer(0, 41, 41); tick();
        offer(0, 42, 42); RST = 1;
        tick(); RST = 0; ldu_in_valid = 0;
        nw(); chk("s7_ready", 32'(ldu_in_ready), 1);
        chk("s7_valid", 32'(ldu_out_valid), 0);
        chk("s7_stall", 32'(ldu_aq_stall_active), 0);
        tick(); mem_act = 0;
        nw(); chk("s7_empty", 32'(ldu_out_valid), 0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
